// File: rtl/operand_select_mux_if.sv
// rtl/operand_select_mux_if.sv - handshake bundle for operand_select_mux
//
// Groups the NUM_IN input channels, the explicit select and the mode
// input, and the registered output channel with its source index.
//   master : operand buffers / downstream (drives in_*, sel, mode, out_ready)
//   slave  : operand_select_mux (drives in_ready, out_data, out_valid, out_src)
interface operand_select_mux_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/operand_select_mux.sv
// rtl/operand_select_mux.sv - NUM_IN:1 registered operand mux with valid/ready handshakes
//
// Picks one of NUM_IN channels (explicit sel, or round-robin scan) and
// registers it into a single output slot that holds under back-pressure.
// Optional feature macro: OPERAND_MUX_RR_EN builds round-robin mode and its
// pointer; without it the mode input is ignored (always explicit select).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - operand_select_mux_if.slave: in_data/in_valid/in_ready per channel,
//          sel, mode, out_data/out_valid/out_ready, out_src
module operand_select_mux #(
    parameter int  WIDTH  = 4,
    parameter int  NUM_IN = 2,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                clk,
    input  logic                rst,
    operand_select_mux_if.slave bus
);
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic              valid_q, valid_d;

    logic [SEL_W-1:0]  chosen;
    logic              chosen_ok;
    logic              chosen_valid;
    logic [WIDTH-1:0]  chosen_data;
    logic              can_accept;
    logic              load;
    logic [NUM_IN-1:0] ready;

`ifdef OPERAND_MUX_RR_EN
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              rr_found;
    logic [SEL_W-1:0]  rr_idx;
    int                rr_pos;

    // Circular scan starting at ptr_q; first valid channel wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            rr_pos = int'(ptr_q) + k;
            if (rr_pos >= NUM_IN) begin
                rr_pos = rr_pos - NUM_IN;
            end
            if (!rr_found && bus.in_valid[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = SEL_W'(rr_pos);
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
`endif

    // Channel choice; an out-of-range sel chooses nothing.
    always_comb begin
        chosen    = bus.sel;
        chosen_ok = ({1'b0, bus.sel} < (SEL_W+1)'(NUM_IN));
`ifdef OPERAND_MUX_RR_EN
        if (bus.mode) begin
            chosen    = rr_idx;
            chosen_ok = rr_found;
        end
`endif
    end

    always_comb begin
        chosen_data  = '0;
        chosen_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (chosen == SEL_W'(i)) begin
                chosen_data  = bus.in_data[i*WIDTH +: WIDTH];
                chosen_valid = bus.in_valid[i];
            end
        end
    end

    // The slot can take new data when empty or draining this cycle;
    // reset blocks all acceptance.
    assign can_accept = !rst && (!valid_q || bus.out_ready);
    assign load       = can_accept && chosen_ok && chosen_valid;

    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ready[i] = can_accept && chosen_ok && (chosen == SEL_W'(i));
        end
    end

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = chosen_data;
            src_d   = chosen;
            valid_d = 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef OPERAND_MUX_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (load && bus.mode) begin
            ptr_d = (chosen == SEL_W'(NUM_IN - 1)) ? '0 : chosen + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_src   = src_q;
endmodule

// File: tb/tb_operand_select_mux.sv
// tb/tb_operand_select_mux.sv - scoreboard bench for operand_select_mux (2-, 3- and 4-channel builds)
module tb_operand_select_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q2[$];
    logic [15:0] q4[$];
    logic [15:0] q3[$];

    operand_select_mux_if #(.WIDTH(4), .NUM_IN(2)) if2 ();
    operand_select_mux_if #(.WIDTH(8), .NUM_IN(4)) if4 ();
    operand_select_mux_if #(.WIDTH(4), .NUM_IN(3)) if3 ();

    operand_select_mux #(.WIDTH(4), .NUM_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    operand_select_mux #(.WIDTH(8), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    operand_select_mux #(.WIDTH(4), .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    // Pops the scoreboards on every output transfer, then advances one clock.
    task automatic tick();
        logic [15:0] exp;
        logic [15:0] got;
        #1;
        if (if2.out_valid && if2.out_ready) begin
            n_checks++;
            got = {8'(if2.out_src), 8'(if2.out_data)};
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL sb2_extra: got src/data %h, required no output", got);
            end else begin
                exp = q2.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sb2_data: got src/data %h, required %h", got, exp);
                end
            end
        end
        if (if4.out_valid && if4.out_ready) begin
            n_checks++;
            got = {8'(if4.out_src), 8'(if4.out_data)};
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL sb4_extra: got src/data %h, required no output", got);
            end else begin
                exp = q4.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sb4_data: got src/data %h, required %h", got, exp);
                end
            end
        end
        if (if3.out_valid && if3.out_ready) begin
            n_checks++;
            got = {8'(if3.out_src), 8'(if3.out_data)};
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL sb3_extra: got src/data %h, required no output", got);
            end else begin
                exp = q3.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sb3_data: got src/data %h, required %h", got, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if2.in_data = '1; if2.in_valid = '1; if2.sel = 1'd1; if2.mode = 1'b0; if2.out_ready = 1'b1;
        if4.in_data = '1; if4.in_valid = '1; if4.sel = 2'd1; if4.mode = 1'b0; if4.out_ready = 1'b1;
        if3.in_data = '1; if3.in_valid = '1; if3.sel = 2'd1; if3.mode = 1'b0; if3.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            n_checks++;
            if ({if2.out_valid, if2.out_data, if2.out_src, if2.in_ready} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset2: valid/data/src/ready %b, required all zero",
                         {if2.out_valid, if2.out_data, if2.out_src, if2.in_ready});
            end
            n_checks++;
            if ({if4.out_valid, if4.out_data, if4.out_src, if4.in_ready} !== 15'h0) begin
                n_fail++;
                $display("FAIL reset4: valid/data/src/ready %b, required all zero",
                         {if4.out_valid, if4.out_data, if4.out_src, if4.in_ready});
            end
            n_checks++;
            if ({if3.out_valid, if3.out_data, if3.out_src, if3.in_ready} !== 10'h0) begin
                n_fail++;
                $display("FAIL reset3: valid/data/src/ready %b, required all zero",
                         {if3.out_valid, if3.out_data, if3.out_src, if3.in_ready});
            end
        end
        rst = 1'b0;
        if2.in_valid = '0;
        if4.in_valid = '0;
        if3.in_valid = '0;
    endtask

    task automatic test_legacy();
        if2.mode = 1'b0; if2.out_ready = 1'b1;
        if2.sel = 1'd1; if2.in_data = {4'hA, 4'h5}; if2.in_valid = 2'b10;
        #1;
        n_checks++;
        if (if2.in_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL legacy_ready1: in_ready %b, required 10", if2.in_ready);
        end
        q2.push_back({8'd1, 8'h0A});
        tick();
        n_checks++;
        if ({if2.out_valid, if2.out_data, if2.out_src} !== {1'b1, 4'hA, 1'b1}) begin
            n_fail++;
            $display("FAIL legacy_out1: valid/data/src %b, required 1_1010_1",
                     {if2.out_valid, if2.out_data, if2.out_src});
        end
        if2.sel = 1'd0; if2.in_valid = 2'b01;
        #1;
        n_checks++;
        if (if2.in_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL legacy_ready0: in_ready %b, required 01", if2.in_ready);
        end
        q2.push_back({8'd0, 8'h05});
        tick();
        if2.in_valid = 2'b00;
        tick();
        n_checks++;
        if (if2.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL legacy_drain: out_valid %b, required 0", if2.out_valid);
        end
    endtask

    task automatic test_back_pressure();
        if4.mode = 1'b0; if4.sel = 2'd2; if4.out_ready = 1'b1;
        if4.in_data = {8'h00, 8'h01, 8'h00, 8'h00}; if4.in_valid = 4'b0100;
        #1;
        n_checks++;
        if (if4.in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_ready_first: in_ready %b, required 0100", if4.in_ready);
        end
        q4.push_back({8'd2, 8'd1});
        tick();
        if4.in_data = {8'h00, 8'h02, 8'h00, 8'h00}; if4.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({if4.in_ready, if4.out_valid, if4.out_data} !== {4'b0000, 1'b1, 8'd1}) begin
                n_fail++;
                $display("FAIL bp_stall: ready/valid/data %b, required 0000_1_00000001",
                         {if4.in_ready, if4.out_valid, if4.out_data});
            end
            tick();
        end
        if4.out_ready = 1'b1;
        #1;
        n_checks++;
        if (if4.in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release: in_ready %b, required 0100", if4.in_ready);
        end
        q4.push_back({8'd2, 8'd2});
        tick();
        if4.in_data = {8'h00, 8'h03, 8'h00, 8'h00};
        q4.push_back({8'd2, 8'd3});
        tick();
        if4.in_valid = 4'b0000;
        tick();
        n_checks++;
        if (if4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: out_valid %b, required 0", if4.out_valid);
        end
    endtask

    task automatic test_out_of_range();
        if3.mode = 1'b0; if3.sel = 2'd0; if3.out_ready = 1'b1;
        if3.in_data = {4'h9, 4'h8, 4'h7}; if3.in_valid = 3'b001;
        q3.push_back({8'd0, 8'h07});
        tick();
        if3.sel = 2'd3; if3.in_valid = 3'b111; if3.out_ready = 1'b0;
        #1;
        n_checks++;
        if ({if3.in_ready, if3.out_valid} !== 4'b0001) begin
            n_fail++;
            $display("FAIL oor_stall: ready/valid %b, required 000_1", {if3.in_ready, if3.out_valid});
        end
        tick();
        if3.out_ready = 1'b1;
        #1;
        n_checks++;
        if (if3.in_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL oor_ready: in_ready %b, required 000", if3.in_ready);
        end
        tick();
        tick();
        n_checks++;
        if ({if3.out_valid, if3.out_data, if3.out_src, if3.in_ready} !== {1'b0, 4'h7, 2'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL oor_drained: valid/data/src/ready %b, required 0_0111_00_000",
                     {if3.out_valid, if3.out_data, if3.out_src, if3.in_ready});
        end
        if3.in_valid = 3'b000;
    endtask

`ifdef OPERAND_MUX_RR_EN
    task automatic test_round_robin();
        logic [1:0] exp_src;
        logic [1:0] gaps [7] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1};
        if4.mode = 1'b1; if4.sel = 2'd0; if4.out_ready = 1'b1;
        if4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        if4.in_valid = 4'b0000;
        #1;
        n_checks++;
        if (if4.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_none: in_ready %b, required 0000", if4.in_ready);
        end
        if4.in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_src = 2'(k % 4);
            #1;
            n_checks++;
            if (if4.in_ready !== 4'(1 << exp_src)) begin
                n_fail++;
                $display("FAIL rr_fair_ready: in_ready %b, required %b", if4.in_ready, 4'(1 << exp_src));
            end
            q4.push_back({8'(exp_src), 8'h10 + 8'(exp_src)});
            tick();
        end
        for (int k = 0; k < 7; k++) begin
            if4.in_valid = (k < 4) ? 4'b1010 : 4'b0010;
            exp_src = gaps[k];
            #1;
            n_checks++;
            if (if4.in_ready !== 4'(1 << exp_src)) begin
                n_fail++;
                $display("FAIL rr_gap_ready: in_ready %b, required %b", if4.in_ready, 4'(1 << exp_src));
            end
            q4.push_back({8'(exp_src), 8'h10 + 8'(exp_src)});
            tick();
        end
        if4.in_valid = 4'b0000;
        tick();
        if4.mode = 1'b0;
    endtask
`else
    task automatic test_mode_ignored();
        if4.mode = 1'b1; if4.sel = 2'd2; if4.out_ready = 1'b1;
        if4.in_valid = 4'b0001;
        #1;
        n_checks++;
        if (if4.in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL mode_ignored: in_ready %b, required 0100", if4.in_ready);
        end
        tick();
        n_checks++;
        if (if4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_ignored_noload: out_valid %b, required 0", if4.out_valid);
        end
        if4.in_valid = 4'b0000;
        if4.mode = 1'b0;
    endtask
`endif

    task automatic test_scoreboard_empty();
        n_checks++;
        if (q2.size() + q4.size() + q3.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected outputs never seen, required 0",
                     q2.size() + q4.size() + q3.size());
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_back_pressure();
        test_out_of_range();
`ifdef OPERAND_MUX_RR_EN
        test_round_robin();
`else
        test_mode_ignored();
`endif
        tick();
        test_scoreboard_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
